safe_lock_ctrl: RTL and testbench

Main access-control FSM of the digital safe lock. It collects keypad digits, compares the completed entry against a stored code, counts failed attempts, and opens or locks out the safe. It is the initiator side of the interval timer's start/done interface: it issues `timer_start` and consumes `timer_done` to time both the open window and the lockout period.

---
 rtl/safe_lock_ctrl_pkg.sv | 20 ++
 rtl/safe_lock_ctrl_if.sv | 38 +++
 rtl/safe_lock_ctrl_digit_buffer.sv | 33 +++
 rtl/safe_lock_ctrl.sv | 106 ++++++++++
 tb/tb_safe_lock_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/safe_lock_ctrl_pkg.sv
// Shared state encodings and defaults for the safe lock controller.
// Also holds the reload value that the interval timer uses.
package safe_lock_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  localparam int          DEF_CODE_LEN  = 4;
  localparam int          DEF_DIGIT_W   = 4;
  localparam int          DEF_MAX_FAILS = 3;
  localparam logic [15:0] DEF_CODE      = 16'h1234;
  localparam int          TIMER_RELOAD  = 10;
  localparam int          CNT_W         = 3;

endpackage

// File: rtl/safe_lock_ctrl_if.sv
// Keypad, control and interval-timer signals of the safe lock.
// master drives keypad/timer inputs, slave is the controller.
interface safe_lock_ctrl_if
  import safe_lock_ctrl_pkg::*;
#(
  parameter int CODE_LEN = DEF_CODE_LEN,
  parameter int DIGIT_W  = DEF_DIGIT_W
);

  logic                        digit_valid;
  logic [DIGIT_W-1:0]          digit;
  logic                        clear;
  logic                        lock_req;
  logic                        code_load;
  logic [CODE_LEN*DIGIT_W-1:0] new_code;
  logic                        timer_done;
  logic                        timer_start;
  logic                        unlocked;
  logic                        locked_out;
  logic                        err;
  logic [1:0]                  fail_count;
  logic [CNT_W-1:0]            digits_entered;

  modport master (
    output digit_valid, digit, clear, lock_req,
    output code_load, new_code, timer_done,
    input  timer_start, unlocked, locked_out,
    input  err, fail_count, digits_entered
  );

  modport slave (
    input  digit_valid, digit, clear, lock_req,
    input  code_load, new_code, timer_done,
    output timer_start, unlocked, locked_out,
    output err, fail_count, digits_entered
  );

endinterface

// File: rtl/safe_lock_ctrl_digit_buffer.sv
// Keypad entry shift register; first digit ends up in the MSBs.
// Also counts how many digits the current entry holds.
module digit_buffer
  import safe_lock_ctrl_pkg::*;
#(
  parameter int CODE_LEN = DEF_CODE_LEN,
  parameter int DIGIT_W  = DEF_DIGIT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        shift_en,
  input  logic                        clr,
  input  logic [DIGIT_W-1:0]          digit,
  output logic [CODE_LEN*DIGIT_W-1:0] data,
  output logic [CNT_W-1:0]            count
);

  localparam int W = CODE_LEN * DIGIT_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      count <= '0;
    end else if (clr) begin
      data  <= '0;
      count <= '0;
    end else if (shift_en) begin
      data  <= {data[W-DIGIT_W-1:0], digit};
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/safe_lock_ctrl.sv
// Access-control FSM of the safe: entry, check, open and lockout.
// Drives the interval timer for the open window and lockout period.
module safe_lock_ctrl
  import safe_lock_ctrl_pkg::*;
#(
  parameter int CODE_LEN  = DEF_CODE_LEN,
  parameter int DIGIT_W   = DEF_DIGIT_W,
  parameter int MAX_FAILS = DEF_MAX_FAILS,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = DEF_CODE
) (
  input logic              clk,
  input logic              rst,
  safe_lock_ctrl_if.slave  bus
);

  localparam int W = CODE_LEN * DIGIT_W;

  state_t         state;
  logic [W-1:0]   code;
  logic [W-1:0]   entry;
  logic           in_entry;
  logic           accept;
  logic           last;
  logic           buf_clr;
  logic           done_q;

  assign in_entry = (state == S_IDLE) || (state == S_ENTRY);
  assign accept   = in_entry && bus.digit_valid && !bus.clear &&
                    (bus.digit <= DIGIT_W'(9));
  assign last     = bus.digits_entered == CNT_W'(CODE_LEN - 1);
  assign buf_clr  = (in_entry && bus.clear) || (state == S_CHECK);
  // timer_done still shows the previous count while timer_start is high
  assign done_q   = bus.timer_done && !bus.timer_start;

  digit_buffer #(
    .CODE_LEN (CODE_LEN),
    .DIGIT_W  (DIGIT_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .clr      (buf_clr),
    .digit    (bus.digit),
    .data     (entry),
    .count    (bus.digits_entered)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      code            <= DEFAULT_CODE;
      bus.unlocked    <= 1'b0;
      bus.locked_out  <= 1'b0;
      bus.err         <= 1'b0;
      bus.timer_start <= 1'b0;
      bus.fail_count  <= 2'd0;
    end else begin
      bus.err         <= 1'b0;
      bus.timer_start <= 1'b0;
      unique case (state)
        S_IDLE, S_ENTRY: begin
          if (in_entry && bus.clear)
            state <= S_IDLE;
          else if (accept && last)
            state <= S_CHECK;
          else if (accept)
            state <= S_ENTRY;
        end
        S_CHECK: begin
          if (entry == code) begin
            state           <= S_OPEN;
            bus.fail_count  <= 2'd0;
            bus.unlocked    <= 1'b1;
            bus.timer_start <= 1'b1;
          end else if (int'(bus.fail_count) + 1 >= MAX_FAILS) begin
            state           <= S_LOCKOUT;
            bus.err         <= 1'b1;
            bus.locked_out  <= 1'b1;
            bus.timer_start <= 1'b1;
          end else begin
            state          <= S_IDLE;
            bus.err        <= 1'b1;
            bus.fail_count <= bus.fail_count + 2'd1;
          end
        end
        S_OPEN: begin
          if (bus.code_load)
            code <= bus.new_code;
          if (bus.lock_req || done_q) begin
            state        <= S_IDLE;
            bus.unlocked <= 1'b0;
          end
        end
        S_LOCKOUT: begin
          if (done_q) begin
            state          <= S_IDLE;
            bus.locked_out <= 1'b0;
            bus.fail_count <= 2'd0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Bench for safe_lock_ctrl with an interval timer model (reload 10).
// Directed vector table plus hand sequences for timing and reset.
module tb_safe_lock_ctrl;
  import safe_lock_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   tcount;

  safe_lock_ctrl_if bus ();

  safe_lock_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tcount <= 0;
    else if (bus.timer_start)
      tcount <= TIMER_RELOAD;
    else if (tcount != 0)
      tcount <= tcount - 1;
  end
  assign bus.timer_done = (tcount == 0);

  typedef struct {
    logic       dv;
    logic [3:0] d;
    logic       clr;
    logic       lreq;
    logic [2:0] de;
    logic       unl;
    logic       er;
    logic       ts;
    logic [1:0] fc;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit       = d;
    tick();
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
  endtask

  task automatic enter(input logic [15:0] c);
    key(c[15:12]);
    key(c[11:8]);
    key(c[7:4]);
    key(c[3:0]);
  endtask

  task automatic relock();
    bus.lock_req = 1'b1;
    tick();
    bus.lock_req = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_unl"}, 32'(bus.unlocked), 0);
    chk({tag, "_lo"},  32'(bus.locked_out), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
    chk({tag, "_ts"},  32'(bus.timer_start), 0);
    chk({tag, "_fc"},  32'(bus.fail_count), 0);
    chk({tag, "_de"},  32'(bus.digits_entered), 0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'hA, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 4'h1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{1'b1, 4'h2, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[3]  = '{1'b1, 4'h3, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[4]  = '{1'b1, 4'h5, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[5]  = '{1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[6]  = '{1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[7]  = '{1'b1, 4'h1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[8]  = '{1'b1, 4'h2, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[9]  = '{1'b1, 4'h3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[10] = '{1'b1, 4'h1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[11] = '{1'b1, 4'h2, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[12] = '{1'b1, 4'h3, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[13] = '{1'b1, 4'h4, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[14] = '{1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 2'd0};
    tbl[15] = '{1'b0, 4'h0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0};

    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    bus.clear       = 1'b0;
    bus.lock_req    = 1'b0;
    bus.code_load   = 1'b0;
    bus.new_code    = 16'h0;

    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // vector table: ignored digit, wrong entry, clear, correct entry
    for (int i = 0; i < 16; i++) begin
      bus.digit_valid = tbl[i].dv;
      bus.digit       = tbl[i].d;
      bus.clear       = tbl[i].clr;
      bus.lock_req    = tbl[i].lreq;
      tick();
      bus.digit_valid = 1'b0;
      bus.clear       = 1'b0;
      bus.lock_req    = 1'b0;
      chk($sformatf("v%0d_de", i),  32'(bus.digits_entered), 32'(tbl[i].de));
      chk($sformatf("v%0d_unl", i), 32'(bus.unlocked), 32'(tbl[i].unl));
      chk($sformatf("v%0d_err", i), 32'(bus.err), 32'(tbl[i].er));
      chk($sformatf("v%0d_ts", i),  32'(bus.timer_start), 32'(tbl[i].ts));
      chk($sformatf("v%0d_fc", i),  32'(bus.fail_count), 32'(tbl[i].fc));
    end

    // open window: 12 cycles T..T+11, idle at T+12
    enter(16'h1234);
    chk("open_chk_unl", 32'(bus.unlocked), 0);
    tick();
    chk("open_t_unl", 32'(bus.unlocked), 1);
    chk("open_t_ts", 32'(bus.timer_start), 1);
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk($sformatf("open_t%0d_unl", k), 32'(bus.unlocked), 1);
      chk($sformatf("open_t%0d_ts", k), 32'(bus.timer_start), 0);
    end
    tick();
    chk("open_end_unl", 32'(bus.unlocked), 0);

    // lockout after three wrong entries
    for (int n = 1; n <= 3; n++) begin
      enter(16'h1235);
      tick();
      chk($sformatf("lk%0d_err", n), 32'(bus.err), 1);
      if (n < 3) begin
        chk($sformatf("lk%0d_fc", n), 32'(bus.fail_count), 32'(n));
        tick();
        chk($sformatf("lk%0d_err_off", n), 32'(bus.err), 0);
      end
    end
    chk("lk_t_lo", 32'(bus.locked_out), 1);
    chk("lk_t_ts", 32'(bus.timer_start), 1);
    for (int k = 1; k <= 11; k++) begin
      bus.digit_valid = 1'b1;
      bus.digit       = 4'(k % 10);
      tick();
      chk($sformatf("lk_t%0d_lo", k), 32'(bus.locked_out), 1);
      chk($sformatf("lk_t%0d_de", k), 32'(bus.digits_entered), 0);
      chk($sformatf("lk_t%0d_err", k), 32'(bus.err), 0);
    end
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    tick();
    chk("lk_end_lo", 32'(bus.locked_out), 0);
    chk("lk_end_fc", 32'(bus.fail_count), 0);

    // code change while open
    enter(16'h1234);
    tick();
    chk("cc_open", 32'(bus.unlocked), 1);
    bus.code_load = 1'b1;
    bus.new_code  = 16'h9876;
    tick();
    bus.code_load = 1'b0;
    chk("cc_load_stay", 32'(bus.unlocked), 1);
    relock();
    chk("cc_relock", 32'(bus.unlocked), 0);
    enter(16'h1234);
    tick();
    chk("cc_old_err", 32'(bus.err), 1);
    chk("cc_old_unl", 32'(bus.unlocked), 0);
    tick();
    enter(16'h9876);
    tick();
    chk("cc_new_unl", 32'(bus.unlocked), 1);
    chk("cc_new_fc", 32'(bus.fail_count), 0);
    relock();

    // reset during entry restores the default code
    key(4'd1);
    key(4'd2);
    chk("re_de", 32'(bus.digits_entered), 2);
    #2 rst = 1'b1;
    #1 chk_zero("re");
    @(negedge clk);
    rst = 1'b0;
    tick();
    enter(16'h1234);
    tick();
    chk("re_code_unl", 32'(bus.unlocked), 1);
    relock();

    // reset in the fifth cycle of lockout
    for (int n = 0; n < 3; n++) begin
      enter(16'h1111);
      tick();
      if (n < 2) tick();
    end
    chk("rl_lo", 32'(bus.locked_out), 1);
    for (int k = 0; k < 4; k++) tick();
    chk("rl_lo5", 32'(bus.locked_out), 1);
    #2 rst = 1'b1;
    #1 chk_zero("rl");
    @(negedge clk);
    rst = 1'b0;
    tick();
    enter(16'h1234);
    tick();
    chk("rl_code_unl", 32'(bus.unlocked), 1);
    relock();
    chk("rl_relock", 32'(bus.unlocked), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
